// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums N_INPUTS unsigned products from the multiplier,
// adds a signed bias, applies ReLU, scales by a right shift and saturates the
// activation to 8 bits. The result is offered on a valid/ready output port.
module neuron_accumulator #(
  parameter int N_INPUTS  = 4,   // products summed per neuron (2..127)
  parameter int ACC_W     = 24,  // signed accumulator width
  parameter int OUT_SHIFT = 8    // right shift before saturation (0..ACC_W-2)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prod_valid,
  input  logic [15:0] prod_data,
  output logic        prod_ready,
  input  logic        flush,
  input  logic [15:0] bias_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sat
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_INPUTS - 1);
  localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'(255);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,  // collecting products
    ST_BIAS  = 2'd1,  // adding the bias
    ST_ACT   = 2'd2,  // ReLU, shift and saturate into the output registers
    ST_OUT   = 2'd3   // holding the result until the consumer takes it
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] bias_ext;
  logic [ACC_W-1:0] acc_shifted;
  logic             acc_negative;
  logic             accept;
  logic             last_product;

  // Products are unsigned and get zero-extended; the bias is two's complement
  // and gets sign-extended so that negative biases subtract.
  assign prod_ext = {{(ACC_W-16){1'b0}}, prod_data};
  assign bias_ext = {{(ACC_W-16){bias_in[15]}}, bias_in};

  // Arithmetic shift of the biased sum; only consumed when the sum is
  // non-negative, where it equals truncating division by 2**OUT_SHIFT.
  assign acc_shifted  = $signed(acc_q) >>> OUT_SHIFT;
  assign acc_negative = acc_q[ACC_W-1];

  // The producer may only hand over a product while collecting and not in reset.
  assign prod_ready   = (state_q == ST_ACCUM) && !reset;
  assign accept       = prod_valid && prod_ready;
  assign last_product = (count_q == LAST_IDX);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Next-state and datapath decode for the four-phase neuron sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      ST_ACCUM: begin
        if (flush) begin
          // Abandon the partial sum; a product offered alongside is dropped.
          acc_d   = '0;
          count_d = '0;
        end else if (accept) begin
          acc_d = acc_q + prod_ext;
          if (last_product) begin
            count_d = '0;
            state_d = ST_BIAS;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      ST_BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = ST_ACT;
      end

      ST_ACT: begin
        if (acc_negative) begin
          out_data_d = 8'd0;
          out_sat_d  = 1'b0;
        end else if (acc_shifted > SAT_LIMIT) begin
          out_data_d = 8'hFF;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = acc_shifted[7:0];
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end

      ST_OUT: begin
        // Data and saturation flag stay put after the handshake; only valid drops.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_neuron_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 24;
  localparam int SH    = 8;

  logic        clk;
  logic        reset;
  logic        prod_valid;
  logic [15:0] prod_data;
  logic        prod_ready;
  logic        flush;
  logic [15:0] bias_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;

  neuron_accumulator #(
    .N_INPUTS (N),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(SH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prod_valid(prod_valid),
    .prod_data (prod_data),
    .prod_ready(prod_ready),
    .flush     (flush),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a running sum and product count per neuron, plus the
  // number of cycles elapsed since the neuron's last product was taken.
  longint      m_sum;
  int          m_cnt;
  bit          m_busy;
  int          m_since;
  logic [7:0]  m_res_data;
  logic        m_res_sat;
  logic [7:0]  m_last_data;
  logic        m_last_sat;
  logic [15:0] cur_bias;
  bit          rand_mode;
  int          prod_mode;

  int          hs_cnt;
  logic [7:0]  cap_data;
  logic        cap_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Activation from the biased sum: ReLU, divide by 2**SH, clip to 255.
  function automatic void activation(input longint s, output logic [7:0] d, output logic sat);
    longint q;
    if (s < 0) begin
      d = 8'd0; sat = 1'b0;
    end else begin
      q = s / (longint'(1) << SH);
      if (q > 255) begin
        d = 8'd255; sat = 1'b1;
      end else begin
        d = 8'(q); sat = 1'b0;
      end
    end
  endfunction

  function automatic logic [15:0] rand_prod(input int mode);
    case (mode)
      0:       return 16'($urandom_range(0, 255));
      1:       return 16'($urandom_range(0, 4095));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic new_neuron_params();
    if (rand_mode) begin
      prod_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) cur_bias = 16'($urandom);
      else cur_bias = 16'($urandom_range(0, 2047) - 1024);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, then
  // advance the model to what the coming edge should do.
  task automatic cyc(input logic r, input logic pv, input logic [15:0] pd,
                     input logic fl, input logic ordy);
    bit exp_valid;
    @(posedge clk);
    #1;
    reset      = r;
    prod_valid = pv;
    prod_data  = pd;
    flush      = fl;
    out_ready  = ordy;
    bias_in    = (m_busy && m_since == 1) ? cur_bias : 16'($urandom);
    #3;
    exp_valid = m_busy && (m_since >= 3);
    check("prod_ready", {31'd0, prod_ready}, {31'd0, !r && !m_busy});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check("out_data", {24'd0, out_data}, {24'd0, exp_valid ? m_res_data : m_last_data});
    check("out_sat", {31'd0, out_sat}, {31'd0, exp_valid ? m_res_sat : m_last_sat});

    if (r) begin
      m_sum = 0; m_cnt = 0; m_busy = 0; m_since = 0;
      m_last_data = 8'd0; m_last_sat = 1'b0;
      new_neuron_params();
    end else if (!m_busy) begin
      if (fl) begin
        m_sum = 0; m_cnt = 0;
      end else if (pv) begin
        m_sum += longint'(pd);
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_busy = 1; m_since = 1;
        end
      end
    end else if (m_since == 1) begin
      m_sum += longint'($signed(cur_bias));
      m_since = 2;
    end else if (m_since == 2) begin
      activation(m_sum, m_res_data, m_res_sat);
      m_since = 3;
    end else if (ordy) begin
      cap_data = out_data;
      cap_sat  = out_sat;
      hs_cnt++;
      m_last_data = m_res_data; m_last_sat = m_res_sat;
      m_sum = 0; m_busy = 0; m_since = 0;
      new_neuron_params();
    end
  endtask

  task automatic feed(input int v0, input int v1, input int v2, input int v3);
    int vals[4];
    vals = '{v0, v1, v2, v3};
    foreach (vals[i]) cyc(1'b0, 1'b1, 16'(vals[i]), 1'b0, 1'b1);
  endtask

  // Idle with out_ready high until one more handshake; bounded.
  task automatic drain(input string tag);
    int start;
    start = hs_cnt;
    for (int i = 0; i < 20 && hs_cnt == start; i++) cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    check({tag, "_handshake_seen"}, {31'd0, hs_cnt != start}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; prod_valid = 1'b0; prod_data = 16'd0; flush = 1'b0;
    bias_in = 16'd0; out_ready = 1'b0;
    m_sum = 0; m_cnt = 0; m_busy = 0; m_since = 0;
    m_res_data = 8'd0; m_res_sat = 1'b0; m_last_data = 8'd0; m_last_sat = 1'b0;
    cur_bias = 16'd0; rand_mode = 0; prod_mode = 0; hs_cnt = 0;
    cap_data = 8'd0; cap_sat = 1'b0;

    assert (longint'(N) * 65535 + 32768 < (longint'(1) << (ACC_W - 1)))
    else begin
      $display("FAIL overflow_bound: accumulator too narrow for N_INPUTS");
      $fatal(1);
    end

    // Reset state.
    cyc(1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);

    // Sum and shift: 1000 >> 8 = 3.
    cur_bias = 16'd0;
    feed(100, 200, 300, 400);
    drain("sum");
    check("sum_data", {24'd0, cap_data}, 32'd3);
    check("sum_sat", {31'd0, cap_sat}, 32'd0);

    // Saturation: 262140 >> 8 = 1023 -> clipped.
    feed(65535, 65535, 65535, 65535);
    drain("sat");
    check("sat_data", {24'd0, cap_data}, 32'd255);
    check("sat_sat", {31'd0, cap_sat}, 32'd1);

    // ReLU: 40 - 100 = -60.
    cur_bias = 16'hFF9C;
    feed(10, 10, 10, 10);
    drain("relu");
    check("relu_data", {24'd0, cap_data}, 32'd0);
    check("relu_sat", {31'd0, cap_sat}, 32'd0);

    // Backpressure: 4000 >> 8 = 15 held for 5 cycles, offered products ignored.
    cur_bias = 16'd0;
    feed(1000, 1000, 1000, 1000);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 16'd777, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'd777, 1'b0, 1'b1);
    check("bp_data", {24'd0, cap_data}, 32'd15);
    feed(256, 256, 256, 256);
    drain("bp_next");
    check("bp_next_data", {24'd0, cap_data}, 32'd4);

    // Reset after two products, then a clean neuron.
    cyc(1'b0, 1'b1, 16'd3000, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'd3000, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'd3000, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    feed(256, 256, 256, 256);
    drain("rst");
    check("rst_data", {24'd0, cap_data}, 32'd4);

    // Flush with a simultaneous product after two accepted products.
    cyc(1'b0, 1'b1, 16'd9000, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'd9000, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'd500, 1'b1, 1'b1);
    feed(512, 512, 512, 512);
    drain("flush");
    check("flush_data", {24'd0, cap_data}, 32'd8);

    // Randomized traffic: gaps, backpressure, flushes (also outside ACCUM),
    // occasional resets, varied product ranges and biases.
    rand_mode = 1;
    new_neuron_params();
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 3) != 0,
          rand_prod(prod_mode),
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) != 0);
    end
    check("random_neurons_completed", {31'd0, hs_cnt > 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Consumes the 16-bit unsigned product stream from the pipelined 8x8 multiplier.
- Sums N_INPUTS products, then adds a signed bias and applies ReLU.
- Scales the result by a right shift and saturates it to 8 bits.
- Presents one activation per neuron on a valid/ready output; sits between the multiplier array and the next layer's operand registers.

Parameters:
N_INPUTS, 4, products summed per neuron (2..127)
ACC_W, 24, signed accumulator width; must hold N_INPUTS*65535 plus the bias magnitude
OUT_SHIFT, 8, right-shift applied to the biased sum before saturation (0..ACC_W-2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
prod_valid  in  1  product on prod_data is valid
prod_data  in  16  unsigned product from the multiplier
prod_ready  out  1  block accepts a product this cycle
flush  in  1  abandon the partial accumulation
bias_in  in  16  signed two's-complement bias, sampled in BIAS state
out_valid  out  1  out_data/out_sat valid
out_ready  in  1  downstream accepts the result
out_data  out  8  unsigned activation
out_sat  out  1  result was clipped to 255

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge.
- Reset state: state=ACCUM, acc=0, count=0, out_valid=0, out_data=0, out_sat=0.
- prod_ready is forced 0 while reset is high.
- Reset mid-operation discards any partial sum or pending result; no output handshake occurs.
- States are ACCUM, BIAS, ACT and OUT.
- ACCUM:
  - prod_ready=1.
  - Accept = prod_valid & prod_ready.
  - On accept: acc += zero-extended prod_data and count += 1.
  - If the accepted product is number N_INPUTS (count == N_INPUTS-1 before the edge), clear count and go to BIAS.
- flush in ACCUM: acc=0, count=0, stay in ACCUM. A simultaneous prod_valid product is dropped, even though prod_ready=1. flush is ignored in every other state.
- BIAS:
  - prod_ready=0.
  - acc += sign-extended bias_in sampled this cycle; go to ACT.
- ACT:
  - prod_ready=0.
  - If acc < 0: out_data=0, out_sat=0.
  - Else s = acc >>> OUT_SHIFT (arithmetic shift; truncation toward zero for non-negative values).
  - If s > 255: out_data=255, out_sat=1. Otherwise out_data=s[7:0], out_sat=0.
  - Set out_valid=1 and go to OUT. All three outputs are registered.
- OUT:
  - prod_ready=0.
  - out_data, out_sat and out_valid are held stable until out_ready=1.
  - On out_valid & out_ready: out_valid=0, acc=0, go to ACCUM. prod_ready=1 on the following cycle.
  - out_data and out_sat keep their last value after the handshake.
- Latency: if the last product is accepted in cycle T, out_valid=1 in cycle T+3.
  - With out_ready held at 1, the next product can be accepted in cycle T+4.
  - Sustained throughput is N_INPUTS+3 cycles per neuron.
- Overflow: with the parameter constraints, acc never wraps and no wrap logic is required. The bench asserts N_INPUTS*65535 + 32768 < 2^(ACC_W-1).
- Products arriving while prod_ready=0 are not consumed; the producer holds them (standard valid/ready).

Test Plan:
- Sum and shift (N=4, OUT_SHIFT=8, bias 0): products 100,200,300,400 accepted in cycles 1-4 -> out_valid=1 in cycle 7, out_data=3 (1000>>8), out_sat=0.
- Saturation: four products of 65535 with bias 0 -> acc=262140, 262140>>8=1023 -> out_data=255, out_sat=1.
- ReLU: products 10,10,10,10 with bias -100 (0xFF9C) -> acc=-60 -> out_data=0, out_sat=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid rises -> out_data/out_sat/out_valid stable, prod_ready=0, offered products not consumed.
  - Raise out_ready -> handshake, prod_ready=1 next cycle, next neuron starts from acc=0.
- Reset mid-accumulation: reset after 2 of 4 products -> out_valid=0, out_data=0, prod_ready=0 during reset. Then four products of 256 with bias 0 -> out_data=4.
- Flush with simultaneous product: flush=1 and prod_valid=1 (value 500) after 2 accepted products. Then four products of 512 with bias 0 -> out_data=8, showing the earlier partial sum and the 500 were discarded.
